// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Region codes decoded from addr[31:28], access-size encodings, the owner
// tag carried by the response register, and a region decode helper.
package mem_port_arbiter_pkg;

  localparam logic [3:0] RegionDmem = 4'b0001;
  localparam logic [3:0] RegionImem = 4'b0010;
  localparam logic [3:0] RegionBoth = 4'b0011;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeBad  = 2'b11
  } size_e;

  typedef enum logic {
    OwnerCpu = 1'b0,
    OwnerDma = 1'b1
  } owner_e;

  typedef struct packed {
    logic dmem;  // access targets dmem
    logic imem;  // store targets imem
    logic bad;   // unmapped region, or load from imem-only region
  } region_dec_t;

  function automatic region_dec_t decode_region(logic [3:0] region, logic we);
    region_dec_t d;
    d = '0;
    case (region)
      RegionDmem: d.dmem = 1'b1;
      RegionImem: begin
        d.imem = 1'b1;
        d.bad  = ~we;
      end
      RegionBoth: begin
        d.dmem = 1'b1;
        d.imem = we;
      end
      default: d.bad = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle for one memory port user.
//   req/we/addr/wdata/size : request, held by the requester until gnt
//   gnt                    : request accepted this cycle (combinational)
//   rvalid                 : load data valid, one cycle after a load grant
// master = requester (CPU or loader), slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        size;
  logic              gnt;
  logic              rvalid;

  modport master (
    output req, we, addr, wdata, size,
    input  gnt, rvalid
  );

  modport slave (
    input  req, we, addr, wdata, size,
    output gnt, rvalid
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for a 32-bit access.
//   size       : 00 byte, 01 half, 10 word, 11 illegal
//   offset     : addr[1:0]
//   wdata      : right-aligned store data
//   mask       : byte-lane write mask
//   data       : store data shifted into its lanes
//   misaligned : illegal size or offset not aligned to the size
module mem_lane_align
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        mask,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  always_comb begin
    mask       = '0;
    misaligned = 1'b0;
    unique case (size_e'(size))
      SizeByte: mask = 4'b0001 << offset;
      SizeHalf: begin
        mask       = 4'b0011 << offset;
        misaligned = offset[0];
      end
      SizeWord: begin
        mask       = 4'b1111;
        misaligned = (offset != 2'b00);
      end
      SizeBad: misaligned = 1'b1;
    endcase
  end

  assign data = wdata << {offset, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared dmem/imem BRAM port between the CPU load/store path
// and the DMA loader.
//   clk, rst             : clock, asynchronous active-high reset
//   cpu, dma             : requester handshakes (slave side)
//   rdata                : dmem read data, passed through unshifted
//   err                  : one-cycle pulse after an illegal request is accepted
//   mem_addr, mem_wdata  : word address and lane-shifted store data
//   dmem_en, dmem_wea    : dmem enable and byte write mask
//   imem_wea             : imem byte write mask
//   dmem_dout            : dmem read data from the BRAM
// CPU has fixed priority, but after STARVE_MAX consecutive contested wins the
// DMA is given the next contested cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave dma,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [13:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              dmem_en,
  output logic [3:0]        dmem_wea,
  output logic [3:0]        imem_wea,
  input  logic [DATA_W-1:0] dmem_dout
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            starve_hit;
  logic            cpu_win, dma_win, any_gnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;
  owner_e            sel_owner;

  logic [3:0]  lane_mask;
  logic        misaligned;
  region_dec_t dec;
  logic        illegal, legal_gnt;

  logic   rsp_valid_q;
  owner_e rsp_owner_q;
  logic   err_q;

  // Arbitration: grants are combinational and suppressed while in reset.
  assign starve_hit = (starve_q == CntW'(STARVE_MAX));
  assign cpu_win    = ~rst & cpu.req & ~(dma.req & starve_hit);
  assign dma_win    = ~rst & dma.req & (~cpu.req | starve_hit);
  assign any_gnt    = cpu_win | dma_win;
  assign cpu.gnt    = cpu_win;
  assign dma.gnt    = dma_win;

  // Counts contested CPU wins; anything else (DMA served or idle) clears it.
  always_comb begin
    starve_d = '0;
    if (cpu_win && dma.req) begin
      starve_d = starve_hit ? starve_q : starve_q + CntW'(1);
    end
  end

  always_comb begin
    sel_owner = dma_win ? OwnerDma : OwnerCpu;
    sel_we    = dma_win ? dma.we    : cpu.we;
    sel_addr  = dma_win ? dma.addr  : cpu.addr;
    sel_wdata = dma_win ? dma.wdata : cpu.wdata;
    sel_size  = dma_win ? dma.size  : cpu.size;
  end

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .size       (sel_size),
    .offset     (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .mask       (lane_mask),
    .data       (mem_wdata),
    .misaligned (misaligned)
  );

  assign dec       = decode_region(sel_addr[31:28], sel_we);
  assign illegal   = misaligned | dec.bad;
  assign legal_gnt = any_gnt & ~illegal;

  assign mem_addr = sel_addr[15:2];
  assign dmem_en  = legal_gnt & dec.dmem;
  assign dmem_wea = (legal_gnt && sel_we && dec.dmem) ? lane_mask : 4'b0000;
  assign imem_wea = (legal_gnt && sel_we && dec.imem) ? lane_mask : 4'b0000;

  // Address bits between the region nibble and the word offset are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^sel_addr[27:16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OwnerCpu;
      err_q       <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rsp_valid_q <= legal_gnt & ~sel_we;
      rsp_owner_q <= sel_owner;
      err_q       <= any_gnt & illegal;
    end
  end

  assign cpu.rvalid = rsp_valid_q & (rsp_owner_q == OwnerCpu);
  assign dma.rvalid = rsp_valid_q & (rsp_owner_q == OwnerDma);
  assign err        = err_q;
  assign rdata      = dmem_dout;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory/instruction-memory access port between the CPU load/store path and the UART/DMA loader requester. Each cycle it grants at most one request, decodes the address region, forms byte-lane write-enables and lane-shifted write data, and routes the one-cycle-latency BRAM read data back to whichever requester was granted. It sits between the MEM stage / loader and the dmem/imem BRAM ports.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (fixed at 32; 4 lanes)
- STARVE_MAX, 4, consecutive contested CPU wins before the DMA is forced a grant
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req, dma_req  in  1  request valid, held until granted
- cpu_we, dma_we  in  1  1 = store, 0 = load
- cpu_addr, dma_addr  in  ADDR_W  byte address
- cpu_wdata, dma_wdata  in  DATA_W  store data, right-aligned
- cpu_size, dma_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_gnt, dma_gnt  out  1  request accepted this cycle
- cpu_rvalid, dma_rvalid  out  1  read data valid (one cycle after load grant)
- rdata  out  DATA_W  BRAM read data, unshifted, muxed from dmem
- err  out  1  one-cycle pulse: accepted request was illegal
- mem_addr  out  14  word address (addr[15:2]) to both BRAMs
- mem_wdata  out  DATA_W  lane-shifted store data
- dmem_en, dmem_wea  out  1, 4  dmem enable, byte write mask
- imem_wea  out  4  imem byte write mask
- dmem_dout  in  DATA_W  dmem read data

## Operation
- Arbitration: CPU has fixed priority; if both request, CPU wins unless starve counter == STARVE_MAX, then DMA wins and counter clears.
- Starve counter: increments on each cycle both request and CPU wins; clears when DMA granted or dma_req low; saturates at STARVE_MAX.
- Grant is combinational from current req (same-cycle), gnt high for exactly the accepted requester.
- Region decode on addr[31:28]: 0001 dmem; 0010 imem (store only); 0011 dmem+imem for stores, dmem for loads; anything else illegal.
- Lane mask: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Write data shifted left by 8*addr[1:0].
- Illegal: size 11, half with addr[0]=1, word with addr[1:0]!=0, load from imem-only region, unmapped region. Request is still granted, both masks 0000, dmem_en 0, err pulses, no rvalid.
- Legal loads: dmem_en 1, masks 0; rvalid to the granted requester next cycle. Legal stores: dmem_en 1 if dmem targeted; masks per region.
- Response tag register holds {valid, owner} for one cycle; rdata = dmem_dout.

## Timing
- Grant, masks, mem_addr, mem_wdata combinational in cycle N; BRAM captures at edge ending N; rvalid and rdata in N+1.
- Back-to-back grants every cycle allowed; a load in N and store in N+1 both proceed.
- Reset: starve counter 0, response tag invalid; all rvalid 0, err 0; masks 0 and gnt 0 while rst high (requests ignored).
- Reset asserted in N+1 after a load grant: rvalid suppressed.
- err registered: pulses in N+1 aligned with where rvalid would be.

## Structure
- Shared package: region codes (DMEM 4'b0001, IMEM 4'b0010, BOTH 4'b0011), size encodings, owner encoding (CPU 0, DMA 1).
- One sub-module: mem_lane_align (combinational: size, offset, wdata -> mask, shifted data, misaligned flag), instantiated once on the granted request.

## Test plan
- CPU sb addr 0x1000_0003 wdata 0xAB -> cpu_gnt, dmem_wea 1000, mem_wdata 0xAB00_0000, imem_wea 0000.
- CPU sw addr 0x3000_0010 -> dmem_wea 1111, imem_wea 1111, mem_addr 4; DMA lw 0x1000_0008 next cycle -> dma_rvalid at N+2 with dmem word 2.
- Both request continuously -> CPU granted 4 cycles, DMA on 5th, pattern repeats.
- CPU sh addr 0x1000_0001 -> cpu_gnt, masks 0000, dmem_en 0, err pulse next cycle, no rvalid.
- CPU lw 0x2000_0000 (imem-only load) -> err, no cpu_rvalid; unmapped 0x8000_0000 store -> err, masks 0.
- Load granted, rst asserted next cycle -> cpu_rvalid stays 0, counter 0 after release.
